// File: rtl/hwpq_test_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module  : hwpq_test_pkg
// Brief   : Shared types and the LFSR tap table for the HWPQ test sequencer.
// Revision: 1.0  initial release
// ============================================================================
package hwpq_test_pkg;

   // Run modes as presented on the mode input; RSVD makes start a no-op.
   typedef enum logic [1:0] {
      FILL  = 2'd0,
      EMPTY = 2'd1,
      MIXED = 2'd2,
      RSVD  = 2'd3
   } mode_t;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_FILL  = 2'd1,
      ST_EMPTY = 2'd2,
      ST_MIXED = 2'd3
   } state_t;

   // Right-shifting Galois feedback masks giving maximal-length sequences.
   // Widths outside the table return zero and are not supported.
   function automatic logic [31:0] lfsr_taps(input int kw);
      case (kw)
         8:       lfsr_taps = 32'h0000_00B8;
         16:      lfsr_taps = 32'h0000_B400;
         24:      lfsr_taps = 32'h00E1_0000;
         32:      lfsr_taps = 32'h8020_0003;
         default: lfsr_taps = 32'h0000_0000;
      endcase
   endfunction

endpackage
`default_nettype wire

// File: rtl/hwpq_test_seq_if.sv
`default_nettype none
// ============================================================================
// Module  : hwpq_test_seq_if
// Brief   : Strobe/status bundle between the test sequencer and the HWPQ.
// Revision: 1.0  initial release
// ============================================================================
interface hwpq_test_seq_if #(
   parameter int KW = 16
);
   logic          enq;
   logic          deq;
   logic [KW-1:0] kvi;
   logic          busy;
   logic          full;
   logic          empty;
   logic [KW-1:0] kvo;

   modport master (output enq, deq, kvi, input busy, full, empty, kvo);
   modport slave  (input enq, deq, kvi, output busy, full, empty, kvo);
endinterface
`default_nettype wire

// File: rtl/hwpq_test_seq_lfsr_gen.sv
`default_nettype none
// ============================================================================
// Module  : lfsr_gen
// Brief   : Galois LFSR key source; advances by one step when enb is high.
// Revision: 1.0  initial release
// ============================================================================
module lfsr_gen #(
   parameter int          KW   = 16,
   parameter logic [31:0] SEED = 32'h0000_ACE1
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          enb,
   output logic [KW-1:0] q
);
   import hwpq_test_pkg::*;

   localparam logic [31:0]   TAPS_FULL = lfsr_taps(KW);
   localparam logic [KW-1:0] TAPS      = TAPS_FULL[KW-1:0];
   localparam logic [KW-1:0] SEED_KW   = SEED[KW-1:0];

   // Shift right, folding the dropped bit back through the tap mask.
   always_ff @(posedge clk) begin
      if (rst) begin
         q <= SEED_KW;
      end else if (enb) begin
         q <= q[0] ? ((q >> 1) ^ TAPS) : (q >> 1);
      end
   end
endmodule
`default_nettype wire

// File: rtl/hwpq_test_seq.sv
`default_nettype none
// ============================================================================
// Module  : hwpq_test_seq
// Brief   : Test sequencer driving a hardware priority queue with LFSR keys:
//           fill, empty (with order check) and mixed random runs.
// Revision: 1.0  initial release
// ============================================================================
module hwpq_test_seq #(
   parameter int          KW        = 16,
   parameter int          CNTW      = 8,
   parameter logic [31:0] SEED      = 32'h0000_ACE1,
   parameter bit          MIN_FIRST = 1'b1
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            start,
   input  logic [1:0]      mode,
   input  logic [CNTW-1:0] count,
   input  logic            abort,
   input  logic            enq_in,
   input  logic            deq_in,
   input  logic [KW-1:0]   kv_in,
   input  logic            r_enb,
   hwpq_test_seq_if.master pq,
   output logic            active,
   output logic            done,
   output logic [CNTW-1:0] ops_cnt,
   output logic            err,
   output logic [CNTW-1:0] err_cnt
);
   import hwpq_test_pkg::*;

   state_t          state;
   logic [CNTW-1:0] remaining;
   logic            limited;   // count was nonzero at start
   logic            first;     // next EMPTY dequeue only seeds prev
   logic [KW-1:0]   prev;
   logic [KW-1:0]   lfsr_q;
   logic            lfsr_adv;
   logic            slot;
   logic            start_ok;
   logic            run_end;
   logic            op_enq;
   logic            op_deq;
   logic            manual;
   logic            order_bad;

   assign slot      = !pq.busy && r_enb && !abort;
   assign start_ok  = start && (mode_t'(mode) != RSVD);
   assign order_bad = MIN_FIRST ? (pq.kvo < prev) : (pq.kvo > prev);
   assign active    = (state != ST_IDLE);

   assign pq.enq = op_enq;
   assign pq.deq = op_deq;
   assign pq.kvi = manual ? kv_in : lfsr_q;

   lfsr_gen #(.KW(KW), .SEED(SEED)) u_lfsr (
      .clk (clk),
      .rst (rst),
      .enb (lfsr_adv),
      .q   (lfsr_q)
   );

   // Mealy strobe decode: which op (if any) this cycle issues, and run end.
   always_comb begin
      op_enq   = 1'b0;
      op_deq   = 1'b0;
      manual   = 1'b0;
      run_end  = 1'b0;
      lfsr_adv = 1'b0;
      case (state)
         ST_IDLE: begin
            if (!start_ok) begin
               if (enq_in) begin
                  op_enq = 1'b1;
                  manual = 1'b1;
               end else if (deq_in && !pq.empty) begin
                  op_deq = 1'b1;
               end
            end
         end
         ST_FILL: begin
            if (slot) begin
               if (pq.full || (limited && remaining == '0)) begin
                  run_end = 1'b1;
               end else begin
                  op_enq   = 1'b1;
                  lfsr_adv = 1'b1;
               end
            end
         end
         ST_EMPTY: begin
            if (slot) begin
               if (pq.empty || (limited && remaining == '0)) begin
                  run_end = 1'b1;
               end else begin
                  op_deq = 1'b1;
               end
            end
         end
         ST_MIXED: begin
            if (slot) begin
               if (remaining == '0) begin
                  run_end = 1'b1;
               end else begin
                  lfsr_adv = 1'b1;
                  // An empty queue forces an enqueue; a full one forces a dequeue.
                  if ((lfsr_q[0] && !pq.full) || pq.empty) begin
                     op_enq = 1'b1;
                  end else begin
                     op_deq = 1'b1;
                  end
               end
            end
         end
         default: ;
      endcase
      if (rst) begin
         op_enq   = 1'b0;
         op_deq   = 1'b0;
         lfsr_adv = 1'b0;
      end
   end

   // Run FSM with counters, order checker and registered done pulse.
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= ST_IDLE;
         remaining <= '0;
         limited   <= 1'b0;
         first     <= 1'b0;
         prev      <= '0;
         ops_cnt   <= '0;
         err       <= 1'b0;
         err_cnt   <= '0;
         done      <= 1'b0;
      end else begin
         done <= 1'b0;
         if (state != ST_IDLE && abort) begin
            state <= ST_IDLE;
         end else if (state == ST_IDLE) begin
            if (start_ok) begin
               remaining <= count;
               limited   <= |count;
               first     <= 1'b1;
               ops_cnt   <= '0;
               err       <= 1'b0;
               err_cnt   <= '0;
               case (mode_t'(mode))
                  FILL:    state <= ST_FILL;
                  EMPTY:   state <= ST_EMPTY;
                  default: state <= ST_MIXED;
               endcase
            end
         end else begin
            if (run_end) begin
               state <= ST_IDLE;
               done  <= 1'b1;
            end
            if (op_enq || op_deq) begin
               ops_cnt   <= ops_cnt + 1'b1;
               remaining <= remaining - 1'b1;
            end
            if (op_deq && state == ST_EMPTY) begin
               prev  <= pq.kvo;
               first <= 1'b0;
               if (!first && order_bad) begin
                  err <= 1'b1;
                  if (err_cnt != '1) begin
                     err_cnt <= err_cnt + 1'b1;
                  end
               end
            end
         end
      end
   end
endmodule
`default_nettype wire

// File: tb/tb_hwpq_test_seq.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module  : tb_hwpq_test_seq
// Brief   : Scoreboard bench for hwpq_test_seq against a depth-8 queue model.
// Revision: 1.0  initial release
// ============================================================================
module tb_hwpq_test_seq;
   import hwpq_test_pkg::*;

   localparam int KW    = 16;
   localparam int CNTW  = 8;
   localparam int DEPTH = 8;

   localparam logic [1:0] EV_ENQ  = 2'd0;
   localparam logic [1:0] EV_DEQ  = 2'd1;
   localparam logic [1:0] EV_DONE = 2'd2;

   typedef struct packed {
      logic [1:0]    kind;
      logic [KW-1:0] key;
   } ev_t;

   logic            clk    = 1'b0;
   logic            rst    = 1'b1;
   logic            start  = 1'b0;
   logic [1:0]      mode   = 2'd0;
   logic [CNTW-1:0] count  = '0;
   logic            abort  = 1'b0;
   logic            enq_in = 1'b0;
   logic            deq_in = 1'b0;
   logic [KW-1:0]   kv_in  = '0;
   logic            r_enb  = 1'b1;
   logic            active;
   logic            done;
   logic [CNTW-1:0] ops_cnt;
   logic            err;
   logic [CNTW-1:0] err_cnt;

   hwpq_test_seq_if #(.KW(KW)) pq ();

   hwpq_test_seq #(.KW(KW), .CNTW(CNTW), .SEED(32'h0000_ACE1), .MIN_FIRST(1'b1)) dut (
      .clk     (clk),
      .rst     (rst),
      .start   (start),
      .mode    (mode),
      .count   (count),
      .abort   (abort),
      .enq_in  (enq_in),
      .deq_in  (deq_in),
      .kv_in   (kv_in),
      .r_enb   (r_enb),
      .pq      (pq),
      .active  (active),
      .done    (done),
      .ops_cnt (ops_cnt),
      .err     (err),
      .err_cnt (err_cnt)
   );

   always #5 clk = ~clk;

   int            n_checks   = 0;
   int            n_fail     = 0;
   int            done_count = 0;
   int            enq_count  = 0;
   ev_t           expq[$];
   logic [KW-1:0] mq[$];
   logic [KW-1:0] lf;
   bit            renb_div   = 1'b0;
   int            tick       = 0;

   // Queue model: sorted insert, head dequeue, flags registered on posedge.
   assign pq.busy = 1'b0;
   always @(posedge clk) begin
      if (!rst) begin
         if (pq.deq && mq.size() > 0) void'(mq.pop_front());
         if (pq.enq) begin
            int pos;
            pos = mq.size();
            for (int i = mq.size() - 1; i >= 0; i--) if (mq[i] > pq.kvi) pos = i;
            mq.insert(pos, pq.kvi);
         end
      end
      pq.full  <= (mq.size() >= DEPTH);
      pq.empty <= (mq.size() == 0);
      pq.kvo   <= (mq.size() > 0) ? mq[0] : '0;
   end

   // Rate enable: always on, or one cycle in four.
   initial forever begin
      @(negedge clk);
      tick++;
      r_enb = renb_div ? (tick % 4 == 0) : 1'b1;
   end

   function automatic logic [15:0] lfsr_next(input logic [15:0] s);
      return s[0] ? ((s >> 1) ^ 16'hB400) : (s >> 1);
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic push_ev(input logic [1:0] kind, input logic [KW-1:0] key);
      ev_t e;
      e.kind = kind;
      e.key  = key;
      expq.push_back(e);
   endtask

   task automatic pop_check(input logic [1:0] kind, input logic [KW-1:0] key);
      ev_t e;
      if (expq.size() == 0) begin
         n_checks++;
         n_fail++;
         $display("FAIL unexpected_event: got kind %0d key %0h expected no event", kind, key);
         return;
      end
      e = expq.pop_front();
      check("event_kind", 32'(kind), 32'(e.kind));
      if (kind == EV_ENQ) check("enq_key", 32'(key), 32'(e.key));
   endtask

   // Monitor: consumes DUT strobes and done pulses against the scoreboard.
   initial forever begin
      @(negedge clk);
      #1;
      if (!rst) begin
         if (done) begin
            done_count++;
            pop_check(EV_DONE, '0);
         end
         if (pq.enq || pq.deq) check("strobe_exclusive", 32'(pq.enq && pq.deq), 0);
         if (pq.enq) begin
            enq_count++;
            check("enq_on_r_enb", 32'(r_enb), 1);
            check("enq_not_full", 32'(pq.full), 0);
            pop_check(EV_ENQ, pq.kvi);
         end
         if (pq.deq) begin
            check("deq_not_empty", 32'(pq.empty), 0);
            pop_check(EV_DEQ, '0);
         end
      end
   end

   task automatic do_start(input logic [1:0] m, input logic [CNTW-1:0] c);
      @(negedge clk);
      start = 1'b1;
      mode  = m;
      count = c;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic wait_done(input int budget, input string name);
      int d0;
      d0 = done_count;
      for (int i = 0; i < budget; i++) begin
         @(negedge clk);
         #2;
         if (done_count != d0) break;
      end
      check(name, 32'(done_count - d0), 1);
      check({name, "_sb_drained"}, 32'(expq.size()), 0);
   endtask

   initial begin
      int            d0;
      int            e0;
      int            sz;
      logic [15:0]   s;

      #200000;
      $display("FAIL watchdog: got timeout expected end of test");
      $fatal(1, "watchdog");
   end

   initial begin
      int          d0;
      int          e0;
      int          sz;
      lf = 16'hACE1;

      // Reset with a manual enqueue request held: strobes must stay low.
      enq_in = 1'b1;
      kv_in  = 16'h00FF;
      repeat (3) @(negedge clk);
      #2;
      check("rst_enq", 32'(pq.enq), 0);
      check("rst_deq", 32'(pq.deq), 0);
      check("rst_active", 32'(active), 0);
      check("rst_done", 32'(done), 0);
      check("rst_ops_cnt", 32'(ops_cnt), 0);
      check("rst_err", 32'(err), 0);
      check("rst_err_cnt", 32'(err_cnt), 0);
      @(negedge clk);
      rst    = 1'b0;
      enq_in = 1'b0;

      // Manual enqueue, manual dequeue, dequeue request on empty, reserved start.
      push_ev(EV_ENQ, 16'h1234);
      push_ev(EV_DEQ, '0);
      @(negedge clk);
      enq_in = 1'b1;
      kv_in  = 16'h1234;
      @(negedge clk);
      enq_in = 1'b0;
      deq_in = 1'b1;
      @(negedge clk);
      @(negedge clk);
      deq_in = 1'b0;
      start  = 1'b1;
      mode   = RSVD;
      count  = 8'd5;
      @(negedge clk);
      start = 1'b0;
      #2;
      check("rsvd_active", 32'(active), 0);
      check("manual_ops_cnt", 32'(ops_cnt), 0);
      check("manual_sb_drained", 32'(expq.size()), 0);

      // FILL unlimited into a depth-8 queue.
      for (int i = 0; i < 8; i++) begin
         push_ev(EV_ENQ, lf);
         lf = lfsr_next(lf);
      end
      push_ev(EV_DONE, '0);
      do_start(FILL, 8'd0);
      wait_done(40, "fill0_done");
      check("fill0_ops_cnt", 32'(ops_cnt), 8);
      check("fill0_active", 32'(active), 0);

      // FILL count=3 with r_enb one cycle in four.
      mq.delete();
      renb_div = 1'b1;
      for (int i = 0; i < 3; i++) begin
         push_ev(EV_ENQ, lf);
         lf = lfsr_next(lf);
      end
      push_ev(EV_DONE, '0);
      do_start(FILL, 8'd3);
      wait_done(60, "fill3_done");
      renb_div = 1'b0;
      check("fill3_ops_cnt", 32'(ops_cnt), 3);

      // EMPTY on a correctly ordered min-queue.
      mq = {16'd5, 16'd9, 16'd9, 16'd20};
      for (int i = 0; i < 4; i++) push_ev(EV_DEQ, '0);
      push_ev(EV_DONE, '0);
      do_start(EMPTY, 8'd0);
      wait_done(40, "empty_ok_done");
      check("empty_ok_err", 32'(err), 0);
      check("empty_ok_err_cnt", 32'(err_cnt), 0);
      check("empty_ok_ops_cnt", 32'(ops_cnt), 4);

      // EMPTY on a faulty queue returning 5,3,7,2.
      mq = {16'd5, 16'd3, 16'd7, 16'd2};
      for (int i = 0; i < 4; i++) push_ev(EV_DEQ, '0);
      push_ev(EV_DONE, '0);
      do_start(EMPTY, 8'd0);
      wait_done(40, "empty_bad_done");
      check("empty_bad_err", 32'(err), 1);
      check("empty_bad_err_cnt", 32'(err_cnt), 2);

      // Next accepted start clears the error state.
      push_ev(EV_DONE, '0);
      do_start(EMPTY, 8'd0);
      wait_done(20, "clear_done");
      check("clear_err", 32'(err), 0);
      check("clear_err_cnt", 32'(err_cnt), 0);
      check("clear_ops_cnt", 32'(ops_cnt), 0);

      // Reset to reload the seed, then MIXED count=20 from empty.
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      mq.delete();
      lf = 16'hACE1;
      sz = 0;
      for (int i = 0; i < 20; i++) begin
         if ((lf[0] && sz < DEPTH) || sz == 0) begin
            push_ev(EV_ENQ, lf);
            sz++;
         end else begin
            push_ev(EV_DEQ, '0);
            sz--;
         end
         lf = lfsr_next(lf);
      end
      push_ev(EV_DONE, '0);
      do_start(MIXED, 8'd20);
      wait_done(100, "mixed_done");
      check("mixed_ops_cnt", 32'(ops_cnt), 20);

      // Abort a FILL run after two enqueues.
      mq.delete();
      for (int i = 0; i < 2; i++) begin
         push_ev(EV_ENQ, lf);
         lf = lfsr_next(lf);
      end
      d0 = done_count;
      e0 = enq_count;
      do_start(FILL, 8'd0);
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         #2;
         if (enq_count >= e0 + 2) break;
      end
      @(negedge clk);
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      #2;
      check("abort_active", 32'(active), 0);
      check("abort_ops_cnt", 32'(ops_cnt), 2);
      repeat (3) @(negedge clk);
      #2;
      check("abort_no_done", 32'(done_count - d0), 0);
      check("abort_ops_held", 32'(ops_cnt), 2);
      check("abort_sb_drained", 32'(expq.size()), 0);

      // Reset in the middle of a FILL run.
      push_ev(EV_ENQ, lf);
      lf = lfsr_next(lf);
      d0 = done_count;
      do_start(FILL, 8'd0);
      @(negedge clk);
      rst = 1'b1;
      #2;
      check("rst_run_enq", 32'(pq.enq), 0);
      @(negedge clk);
      rst = 1'b0;
      #2;
      check("rst_run_active", 32'(active), 0);
      check("rst_run_ops_cnt", 32'(ops_cnt), 0);
      check("rst_run_err", 32'(err), 0);
      check("rst_run_err_cnt", 32'(err_cnt), 0);
      check("rst_run_enq_idle", 32'(pq.enq), 0);
      check("rst_run_deq_idle", 32'(pq.deq), 0);
      repeat (3) @(negedge clk);
      #2;
      check("rst_run_no_done", 32'(done_count - d0), 0);
      check("rst_run_done", 32'(done), 0);
      check("rst_run_sb_drained", 32'(expq.size()), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
`default_nettype wire

// File: doc/hwpq_test_seq.md
Name: hwpq_test_seq

Overview:
Parametrised test sequencer that drives a hardware priority queue (HWPQ) with pseudorandom keys from an internal LFSR. Supported runs: count-limited fill, count-limited empty, and a mixed random enqueue/dequeue sequence. It also checks that keys leave the queue in priority order during empty runs. It sits between board-level controls (buttons/switches) and the HWPQ under test.

Parameters:
KW, 16, key width; also the LFSR width.
CNTW, 8, width of the operation count and statistics counters.
SEED, 16'hACE1, LFSR value at reset; must be nonzero; truncated/extended to KW.
MIN_FIRST, 1, 1 = smallest key has highest priority; 0 = largest key first.

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
start  in  1  start a run using mode/count; sampled only in IDLE
mode  in  2  0=FILL, 1=EMPTY, 2=MIXED, 3=reserved (start ignored)
count  in  CNTW  number of operations; 0 = unlimited for FILL/EMPTY
abort  in  1  end the current run immediately
enq_in  in  1  manual enqueue of kv_in (IDLE only)
deq_in  in  1  manual dequeue (IDLE only)
kv_in  in  KW  manual key
r_enb  in  1  rate enable; an op may issue only when r_enb=1
busy  in  1  HWPQ busy
full  in  1  HWPQ full
empty  in  1  HWPQ empty
kvo  in  KW  HWPQ head key; valid when !empty && !busy
enq  out  1  enqueue strobe to HWPQ
deq  out  1  dequeue strobe to HWPQ
kvi  out  KW  key to HWPQ: kv_in when manual enqueue, LFSR state otherwise
active  out  1  run in progress (state != IDLE)
done  out  1  one-cycle pulse when a run completes normally
ops_cnt  out  CNTW  operations issued in current/last run
err  out  1  sticky order-violation flag; cleared on accepted start
err_cnt  out  CNTW  order-violation count; saturates at all-ones; cleared on accepted start

Behaviour:
- Reset: state=IDLE, LFSR=SEED, all registered outputs 0. enq/deq=0 during reset.
- Reset mid-run returns to IDLE with no done pulse.
- enq, deq, kvi are combinational (Mealy) on state and inputs. Strobes are at most one cycle per op. enq and deq are never asserted together.
- Issue slot: a cycle with !busy && r_enb && !abort while in a run state.
- States: IDLE, FILL, EMPTY, MIXED.
- IDLE, start with mode<3: load remaining=count, clear ops_cnt/err/err_cnt, go to mode state next cycle. No op is issued in that cycle.
- IDLE priority: start > enq_in > deq_in. enq_in asserts enq for one cycle with kvi=kv_in. deq_in asserts deq only if !empty. Manual ops do not touch ops_cnt or the LFSR.
- FILL, per issue slot: if full, or (count!=0 and remaining==0), go to IDLE and pulse done. Otherwise assert enq with kvi=LFSR, advance the LFSR, increment ops_cnt, decrement remaining.
- EMPTY: same as FILL, using empty and deq. On each deq, capture kvo into prev.
  - The first deq of a run only loads prev.
  - On later deqs, kvo<prev (MIN_FIRST=1) or kvo>prev (MIN_FIRST=0) sets err and increments err_cnt.
  - Equal keys are legal.
- MIXED:
  - count==0 ends the run at the first issue slot with done and no op.
  - Per issue slot, want_enq=LFSR[0]. Enqueue if (want_enq && !full) || empty; otherwise dequeue.
  - The LFSR advances every slot and kvi is the pre-advance LFSR value.
  - Run ends with done when remaining reaches 0, evaluated at the next issue slot.
  - No order checking in MIXED.
- Non-issue cycles in a run state: no strobes, no state change.
- abort in a run state: no strobe that cycle, go to IDLE next cycle, no done. ops_cnt and err are retained.
- start, enq_in and deq_in are ignored outside IDLE.
- LFSR: Galois, maximal-length for KW, never reaches zero. Taps are chosen from a package table for KW in {8,16,24,32}; other KW values are illegal.
- ops_cnt wraps modulo 2^CNTW for unlimited runs.

Decomposition:
- Package hwpq_test_pkg: mode_t enum (FILL, EMPTY, MIXED, RSVD); state_t enum; function lfsr_taps(KW) returning the tap mask.
- Sub-module lfsr_gen (params KW, SEED; ports clk, rst, enb, q), instantiated once.

Test Plan:
- Reset, then FILL count=0 against a depth-8 queue model (busy=0, r_enb=1) -> 8 enq pulses with 8 distinct nonzero keys, done at the cycle full=1 is seen, ops_cnt=8.
- FILL count=3 on an empty queue with r_enb toggling 1-of-4 cycles -> exactly 3 enq pulses, each on an r_enb=1 cycle, then done; LFSR advanced 3 times.
- EMPTY count=0 on a correctly sorted min-queue holding 5,9,9,20 -> 4 deq pulses, done, err=0, err_cnt=0.
- EMPTY with a faulty model returning 5,3,7,2 -> err=1, err_cnt=2; cleared on the next accepted start.
- MIXED count=20 from empty -> 20 ops total, no deq while empty, no enq while full, enq/deq never both high, done once.
- abort mid-FILL after 2 ops, then rst asserted during a later run -> no done pulse either time, IDLE next cycle, ops_cnt=2 held after abort; all outputs 0 after rst.
